// File: rtl/regfile_sync_clear.sv
// Two-read/one-write register file with registered write-first reads, per-entry
// dirty tracking and a sequential clear sweep. Define REGFILE_ZERO_REG_EN to hardwire entry 0 to zero.
module regfile_sync_clear #(
    parameter  int DATA_W = 8,
    parameter  int ADDR_W = 3,
    localparam int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              clear_req,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              busy,
    output logic [DEPTH-1:0]  dirty
);

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt_next;

    logic [DATA_W-1:0]   r_mem      [DEPTH];
    logic [DATA_W-1:0]   w_mem_next [DEPTH];
    logic [DEPTH-1:0]    r_dirty;
    logic [DEPTH-1:0]    w_dirty_next;

    logic                w_busy;
    logic                w_wr_accept;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // FSM next state
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (clear_req) begin
                    w_state_next = S_CLEAR;
                    w_cnt_next   = '0;
                end
            end
            S_CLEAR: begin
                if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // FSM outputs: a write only lands in IDLE, loses to a same-edge clear, and never touches a hardwired entry 0
    always_comb begin
        w_busy      = (r_state == S_CLEAR);
        w_wr_accept = (r_state == S_IDLE) && write_en && !clear_req
                      && !(ZERO_REG && (write_addr == '0));
    end

    assign busy  = w_busy;
    assign dirty = r_dirty;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            if (ZERO_REG && gi == 0) begin : g_zero
                assign w_mem_next[gi]   = '0;
                assign w_dirty_next[gi] = 1'b0;
            end else begin : g_reg
                logic w_clr_hit;
                logic w_wr_hit;
                assign w_clr_hit = w_busy && (r_cnt == ADDR_W'(gi));
                assign w_wr_hit  = w_wr_accept && (write_addr == ADDR_W'(gi));
                assign w_mem_next[gi]   = w_clr_hit ? '0 :
                                          w_wr_hit  ? write_data : r_mem[gi];
                assign w_dirty_next[gi] = w_clr_hit ? 1'b0 :
                                          w_wr_hit  ? 1'b1 : r_dirty[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_dirty <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= w_mem_next[i];
            end
            r_dirty <= w_dirty_next;
        end
    end

    logic [ADDR_W-1:0] w_raddr [2];
    logic [DATA_W-1:0] r_rdata [2];

    assign w_raddr[0] = read_addr1;
    assign w_raddr[1] = read_addr2;

    // Read ports: zero during a sweep, otherwise write-first bypass over the array
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rport
            logic w_byp;
            logic w_zero;
            assign w_byp  = w_wr_accept && (write_addr == w_raddr[gi]);
            assign w_zero = ZERO_REG && (w_raddr[gi] == '0);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rdata[gi] <= '0;
                end else if (w_busy || w_zero) begin
                    r_rdata[gi] <= '0;
                end else if (w_byp) begin
                    r_rdata[gi] <= write_data;
                end else begin
                    r_rdata[gi] <= r_mem[w_raddr[gi]];
                end
            end
        end
    endgenerate

    assign read_data1 = r_rdata[0];
    assign read_data2 = r_rdata[1];

endmodule

// File: tb/tb_regfile_sync_clear.sv
// Self-checking bench for regfile_sync_clear: array/queue reference model compared every
// cycle, plus directed literal expectations. Honours REGFILE_ZERO_REG_EN when defined.
module tb_regfile_sync_clear;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int N  = 8;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [AW-1:0] read_addr1;
    logic [AW-1:0] read_addr2;
    logic          write_en;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic          clear_req;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] read_data2;
    logic          busy;
    logic [N-1:0]  dirty;

    regfile_sync_clear #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .read_addr1 (read_addr1),
        .read_addr2 (read_addr2),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .clear_req  (clear_req),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .busy       (busy),
        .dirty      (dirty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents, written-set and a list of entries still to be swept
    logic [DW-1:0] m_mem [N];
    logic [N-1:0]  m_dirty;
    int            m_sweep_q [$];
    logic [DW-1:0] m_rd1, m_rd2;
    bit            m_valid = 1'b0;

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] ra, input bit wr_ok);
        if (ZERO && ra == 0) return '0;
        if (wr_ok && write_addr == ra) return write_data;
        return m_mem[ra];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_dirty = '0;
            m_sweep_q.delete();
            m_rd1 = '0;
            m_rd2 = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_sweep_q.size() > 0) begin
                int e;
                e = m_sweep_q.pop_front();
                m_mem[e]   = '0;
                m_dirty[e] = 1'b0;
                m_rd1 = '0;
                m_rd2 = '0;
            end else begin
                bit wr_ok;
                wr_ok = write_en && !clear_req && !(ZERO && write_addr == 0);
                m_rd1 = model_read(read_addr1, wr_ok);
                m_rd2 = model_read(read_addr2, wr_ok);
                if (wr_ok) begin
                    m_mem[write_addr]   = write_data;
                    m_dirty[write_addr] = 1'b1;
                end
                if (clear_req) begin
                    for (int i = 0; i < N; i++) m_sweep_q.push_back(i);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("rd1",   32'(read_data1), 32'(m_rd1));
            check("rd2",   32'(read_data2), 32'(m_rd2));
            check("busy",  32'(busy),       32'(m_sweep_q.size() > 0));
            check("dirty", 32'(dirty),      32'(m_dirty));
        end
    end

    task automatic step(input bit we, input int wa, input logic [DW-1:0] wd,
                        input int ra1, input int ra2, input bit clr);
        write_en   = we;
        write_addr = AW'(wa);
        write_data = wd;
        read_addr1 = AW'(ra1);
        read_addr2 = AW'(ra2);
        clear_req  = clr;
        $display("t=%0t rst=%0b we=%0b wa=%0d wd=0x%02h ra1=%0d ra2=%0d clr=%0b", $time,
                 rst, we, wa, wd, ra1, ra2, clr);
        @(negedge clk);
    endtask

    int cnt;

    initial begin
        rst = 1'b1;
        write_en = 1'b0; write_addr = '0; write_data = '0;
        read_addr1 = '0; read_addr2 = '0; clear_req = 1'b0;
        @(negedge clk);
        step(0, 0, 8'h00, 3, 3, 0);
        check("reset_rd1", 32'(read_data1), 32'h00);
        check("reset_dirty", 32'(dirty), 32'h00);
        rst = 1'b0;

        // Write then read
        step(1, 3, 8'hA5, 0, 0, 0);
        step(0, 0, 8'h00, 3, 0, 0);
        check("wr_rd_a5", 32'(read_data1), 32'hA5);
        check("dirty_a5", 32'(dirty), 32'h08);

        // Bypass on both ports, then one port reading a different entry
        step(1, 2, 8'h22, 0, 0, 0);
        step(1, 5, 8'h3C, 5, 5, 0);
        check("byp_rd1", 32'(read_data1), 32'h3C);
        check("byp_rd2", 32'(read_data2), 32'h3C);
        step(1, 5, 8'h4D, 5, 2, 0);
        check("byp2_rd1", 32'(read_data1), 32'h4D);
        check("old_rd2",  32'(read_data2), 32'h22);

        // Fill, sweep with attempted writes, verify
        for (int i = 0; i < N; i++) step(1, i, 8'hFF, i, N - 1 - i, 0);
        step(0, 0, 8'h00, 1, 2, 1);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (busy) cnt++;
            step(busy, i % N, 8'h55, i % N, (i + 3) % N, 0);
        end
        check("sweep_len", 32'(cnt), 32'd8);
        check("sweep_dirty", 32'(dirty), 32'h00);
        for (int i = 0; i < N; i++) step(0, 0, 8'h00, i, i, 0);

        // Clear/write collision and re-request during sweep
        step(1, 1, 8'h11, 1, 1, 1);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (busy) cnt++;
            step(0, 0, 8'h00, 1, 1, (i == 2));
        end
        check("collide_len", 32'(cnt), 32'd8);
        step(0, 0, 8'h00, 1, 1, 0);
        check("collide_rd1", 32'(read_data1), 32'h00);
        check("collide_dirty", 32'(dirty), 32'h00);

        // Reset on the fourth sweep cycle
        step(1, 4, 8'h44, 0, 0, 0);
        step(1, 7, 8'h77, 0, 0, 0);
        step(0, 0, 8'h00, 0, 0, 1);
        cnt = 0;
        for (int i = 0; i < 20 && cnt < 3; i++) begin
            if (busy) cnt++;
            step(0, 0, 8'h00, 4, 7, 0);
        end
        check("mid_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        step(0, 0, 8'h00, 4, 7, 0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_dirty", 32'(dirty), 32'h00);
        rst = 1'b0;
        step(1, 6, 8'h66, 4, 7, 0);
        check("rst_mid_rd1", 32'(read_data1), 32'h00);
        check("rst_mid_rd2", 32'(read_data2), 32'h00);
        step(0, 0, 8'h00, 6, 7, 0);
        check("post_rst_wr", 32'(read_data1), 32'h66);
        check("post_rst_dirty", 32'(dirty), 32'h40);

        // Address 0: hardwired zero when the option is built in, ordinary otherwise
        step(1, 0, 8'h77, 0, 0, 0);
        check("a0_byp", 32'(read_data1), ZERO ? 32'h00 : 32'h77);
        step(0, 0, 8'h00, 0, 0, 0);
        check("a0_rd", 32'(read_data2), ZERO ? 32'h00 : 32'h77);
        check("a0_dirty", 32'(dirty[0]), ZERO ? 32'h0 : 32'h1);

        step(0, 0, 8'h00, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
